// File: rtl/fb_sram_arbiter_if.sv
// Request/response bundle between the framebuffer requesters, the arbiter and
// the single-port SRAM controller. The arbiter sits on the slave side.
interface fb_sram_arbiter_if #(
  parameter int ADDR_BITS = 20,
  parameter int DATA_BITS = 16
);
  logic                 rd_valid;
  logic [ADDR_BITS-1:0] rd_addr;
  logic                 rd_ready;
  logic                 rd_rsp_valid;
  logic [DATA_BITS-1:0] rd_rsp_data;
  logic                 wr_valid;
  logic [ADDR_BITS-1:0] wr_addr;
  logic [DATA_BITS-1:0] wr_data;
  logic                 wr_ready;
  logic                 clear_start;
  logic                 clear_busy;
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic                 cmd_we;
  logic [ADDR_BITS-1:0] cmd_addr;
  logic [DATA_BITS-1:0] cmd_wdata;
  logic                 rsp_valid;
  logic [DATA_BITS-1:0] rsp_data;

  modport slave (
    input  rd_valid, rd_addr, wr_valid, wr_addr, wr_data, clear_start,
           cmd_ready, rsp_valid, rsp_data,
    output rd_ready, rd_rsp_valid, rd_rsp_data, wr_ready, clear_busy,
           cmd_valid, cmd_we, cmd_addr, cmd_wdata
  );

  modport master (
    output rd_valid, rd_addr, wr_valid, wr_addr, wr_data, clear_start,
           cmd_ready, rsp_valid, rsp_data,
    input  rd_ready, rd_rsp_valid, rd_rsp_data, wr_ready, clear_busy,
           cmd_valid, cmd_we, cmd_addr, cmd_wdata
  );
endinterface

// File: rtl/fb_sram_arbiter.sv
// Shares one SRAM command port between the clear engine, display reads and
// pixel writes (priority in that order) with a write starvation guard.
module fb_sram_arbiter #(
  parameter int ADDR_BITS     = 20,
  parameter int DATA_BITS     = 16,
  parameter int FB_WORDS      = 307200,
  parameter int CLEAR_VALUE   = 0,
  parameter int WR_STARVE_MAX = 8,
  parameter int RD_MAX_OUTST  = 4
) (
  input logic                clk,
  input logic                reset_n,
  fb_sram_arbiter_if.slave   bus
);
  localparam int STW = $clog2(WR_STARVE_MAX + 1);
  localparam int OTW = $clog2(RD_MAX_OUTST + 1);
  localparam logic [STW-1:0]       STARVE_MAX = STW'(WR_STARVE_MAX);
  localparam logic [OTW-1:0]       OUTST_MAX  = OTW'(RD_MAX_OUTST);
  localparam logic [ADDR_BITS-1:0] LAST_ADDR  = ADDR_BITS'(FB_WORDS - 1);
  localparam logic [DATA_BITS-1:0] CLR_DATA   = DATA_BITS'(CLEAR_VALUE);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DRAIN = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [ADDR_BITS-1:0] clr_addr_q, clr_addr_d;
  logic [STW-1:0]       starve_q, starve_d;
  logic [OTW-1:0]       outst_q, outst_d;
  logic                 cmd_valid_q, cmd_valid_d;
  logic                 cmd_we_q, cmd_we_d;
  logic [ADDR_BITS-1:0] cmd_addr_q, cmd_addr_d;
  logic [DATA_BITS-1:0] cmd_wdata_q, cmd_wdata_d;
  logic                 load_s;
  logic                 rd_gnt_s;
  logic                 wr_gnt_s;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      clr_addr_q  <= {ADDR_BITS{1'b0}};
      starve_q    <= {STW{1'b0}};
      outst_q     <= {OTW{1'b0}};
      cmd_valid_q <= 1'b0;
      cmd_we_q    <= 1'b0;
      cmd_addr_q  <= {ADDR_BITS{1'b0}};
      cmd_wdata_q <= {DATA_BITS{1'b0}};
    end else begin
      state_q     <= state_d;
      clr_addr_q  <= clr_addr_d;
      starve_q    <= starve_d;
      outst_q     <= outst_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_we_q    <= cmd_we_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_wdata_q <= cmd_wdata_d;
    end
  end

  always_comb begin
    load_s      = !cmd_valid_q || bus.cmd_ready;
    state_d     = state_q;
    clr_addr_d  = clr_addr_q;
    cmd_valid_d = cmd_valid_q;
    cmd_we_d    = cmd_we_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_wdata_d = cmd_wdata_q;
    rd_gnt_s    = 1'b0;
    wr_gnt_s    = 1'b0;

    // Requesters only compete in IDLE; a forced write beats reads once starved.
    if (state_q == IDLE && load_s) begin
      if (bus.wr_valid && starve_q == STARVE_MAX) begin
        wr_gnt_s = 1'b1;
      end else if (bus.rd_valid && outst_q < OUTST_MAX) begin
        rd_gnt_s = 1'b1;
      end else if (bus.wr_valid) begin
        wr_gnt_s = 1'b1;
      end else begin
        wr_gnt_s = 1'b0;
      end
    end else begin
      rd_gnt_s = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (bus.clear_start) begin
          state_d    = CLEAR;
          clr_addr_d = {ADDR_BITS{1'b0}};
        end else begin
          state_d = IDLE;
        end
      end
      CLEAR: begin
        if (load_s) begin
          if (clr_addr_q == LAST_ADDR) begin
            state_d = DRAIN;
          end else begin
            clr_addr_d = clr_addr_q + {{(ADDR_BITS-1){1'b0}}, 1'b1};
          end
        end else begin
          state_d = CLEAR;
        end
      end
      DRAIN: begin
        if (load_s) begin
          state_d = IDLE;
        end else begin
          state_d = DRAIN;
        end
      end
      default: state_d = IDLE;
    endcase

    if (load_s) begin
      if (state_q == CLEAR) begin
        cmd_valid_d = 1'b1;
        cmd_we_d    = 1'b1;
        cmd_addr_d  = clr_addr_q;
        cmd_wdata_d = CLR_DATA;
      end else if (rd_gnt_s) begin
        cmd_valid_d = 1'b1;
        cmd_we_d    = 1'b0;
        cmd_addr_d  = bus.rd_addr;
        cmd_wdata_d = {DATA_BITS{1'b0}};
      end else if (wr_gnt_s) begin
        cmd_valid_d = 1'b1;
        cmd_we_d    = 1'b1;
        cmd_addr_d  = bus.wr_addr;
        cmd_wdata_d = bus.wr_data;
      end else begin
        cmd_valid_d = 1'b0;
      end
    end else begin
      cmd_valid_d = cmd_valid_q;
    end

    if (!bus.wr_valid || wr_gnt_s) begin
      starve_d = {STW{1'b0}};
    end else if (load_s && starve_q != STARVE_MAX) begin
      starve_d = starve_q + {{(STW-1){1'b0}}, 1'b1};
    end else begin
      starve_d = starve_q;
    end

    // A response with nothing outstanding is a protocol error; never wrap below 0.
    case ({rd_gnt_s, bus.rsp_valid})
      2'b10:   outst_d = outst_q + {{(OTW-1){1'b0}}, 1'b1};
      2'b01:   outst_d = (outst_q == {OTW{1'b0}}) ? outst_q
                                                  : outst_q - {{(OTW-1){1'b0}}, 1'b1};
      default: outst_d = outst_q;
    endcase
  end

  assign bus.rd_ready     = rd_gnt_s & reset_n;
  assign bus.wr_ready     = wr_gnt_s & reset_n;
  assign bus.rd_rsp_valid = bus.rsp_valid;
  assign bus.rd_rsp_data  = bus.rsp_data;
  assign bus.clear_busy   = (state_q != IDLE);
  assign bus.cmd_valid    = cmd_valid_q;
  assign bus.cmd_we       = cmd_we_q;
  assign bus.cmd_addr     = cmd_addr_q;
  assign bus.cmd_wdata    = cmd_wdata_q;
endmodule

// File: tb/tb_fb_sram_arbiter.sv
// Directed bench for fb_sram_arbiter: vector table for single-command cases,
// hand sequences for starvation, read credit, clear and mid-clear reset.
module tb_fb_sram_arbiter;
  localparam int AB  = 20;
  localparam int DB  = 16;
  localparam int FBW = 16;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  fb_sram_arbiter_if #(.ADDR_BITS(AB), .DATA_BITS(DB)) bus ();

  fb_sram_arbiter #(
    .ADDR_BITS(AB), .DATA_BITS(DB), .FB_WORDS(FBW), .CLEAR_VALUE(0),
    .WR_STARVE_MAX(8), .RD_MAX_OUTST(4)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  typedef struct {
    logic          rv;
    logic [AB-1:0] ra;
    logic          wv;
    logic [AB-1:0] wa;
    logic [DB-1:0] wd;
    logic          cs;
    logic          cr;
    logic          rsv;
    logic [DB-1:0] rsd;
    logic          e_rrdy;
    logic          e_wrdy;
    logic          e_cv;
    logic          e_we;
    logic [AB-1:0] e_addr;
    logic [DB-1:0] e_wd;
  } vec_t;

  vec_t          vt[11];
  int            n_vec = 0;
  int            n_err = 0;
  logic          acc;
  logic          found;
  logic          fin;
  int            n_wr;
  int            n_cmd;
  logic [AB-1:0] log_addr[32];
  logic [DB:0]   log_wd[32];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rv, input logic [AB-1:0] ra, input logic wv,
                       input logic [AB-1:0] wa, input logic [DB-1:0] wd, input logic cs,
                       input logic cr, input logic rsv, input logic [DB-1:0] rsd);
    bus.rd_valid    = rv;
    bus.rd_addr     = ra;
    bus.wr_valid    = wv;
    bus.wr_addr     = wa;
    bus.wr_data     = wd;
    bus.clear_start = cs;
    bus.cmd_ready   = cr;
    bus.rsp_valid   = rsv;
    bus.rsp_data    = rsd;
  endtask

  task automatic rd_step(input logic rv, input logic rsv, input logic exp_rdy, input int k);
    drive(rv, 20'h00100, 1'b0, 20'h0, 16'h0, 1'b0, 1'b1, rsv, 16'h5A5A);
    #1;
    chk($sformatf("t6_rd_ready_%0d", k), {31'd0, bus.rd_ready}, {31'd0, exp_rdy});
    @(negedge clk);
  endtask

  initial begin
    vt[0]  = '{1'b1, 20'h00010, 1'b0, 20'h0, 16'h0, 1'b0, 1'b1, 1'b0, 16'h0,
               1'b1, 1'b0, 1'b1, 1'b0, 20'h00010, 16'h0};
    vt[1]  = '{1'b0, 20'h0, 1'b0, 20'h0, 16'h0, 1'b0, 1'b1, 1'b1, 16'hBEEF,
               1'b0, 1'b0, 1'b0, 1'b0, 20'h0, 16'h0};
    vt[2]  = '{1'b0, 20'h0, 1'b1, 20'h00123, 16'hA5A5, 1'b0, 1'b0, 1'b0, 16'h0,
               1'b0, 1'b1, 1'b1, 1'b1, 20'h00123, 16'hA5A5};
    for (int i = 3; i < 8; i++) begin
      vt[i] = '{1'b1, 20'h00020, 1'b1, 20'h00124, 16'h1111, 1'b0, 1'b0, 1'b0, 16'h0,
                1'b0, 1'b0, 1'b1, 1'b1, 20'h00123, 16'hA5A5};
    end
    vt[8]  = '{1'b1, 20'h00020, 1'b1, 20'h00124, 16'h1111, 1'b0, 1'b1, 1'b0, 16'h0,
               1'b1, 1'b0, 1'b1, 1'b0, 20'h00020, 16'h0};
    vt[9]  = '{1'b0, 20'h0, 1'b1, 20'h00124, 16'h1111, 1'b0, 1'b1, 1'b0, 16'h0,
               1'b0, 1'b1, 1'b1, 1'b1, 20'h00124, 16'h1111};
    vt[10] = '{1'b0, 20'h0, 1'b0, 20'h0, 16'h0, 1'b0, 1'b1, 1'b1, 16'h0042,
               1'b0, 1'b0, 1'b0, 1'b0, 20'h0, 16'h0};

    // Reset state, with requests pending so ready gating is exercised.
    drive(1'b1, 20'h00010, 1'b1, 20'h00011, 16'h1234, 1'b0, 1'b1, 1'b0, 16'h0);
    #1;
    chk("rst_rd_ready", {31'd0, bus.rd_ready}, 32'd0);
    chk("rst_wr_ready", {31'd0, bus.wr_ready}, 32'd0);
    chk("rst_cmd_valid", {31'd0, bus.cmd_valid}, 32'd0);
    chk("rst_cmd_we", {31'd0, bus.cmd_we}, 32'd0);
    chk("rst_cmd_addr", {12'd0, bus.cmd_addr}, 32'd0);
    chk("rst_cmd_wdata", {16'd0, bus.cmd_wdata}, 32'd0);
    chk("rst_clear_busy", {31'd0, bus.clear_busy}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    drive(1'b0, 20'h0, 1'b0, 20'h0, 16'h0, 1'b0, 1'b1, 1'b0, 16'h0);
    reset_n = 1'b1;

    for (int i = 0; i < 11; i++) begin
      drive(vt[i].rv, vt[i].ra, vt[i].wv, vt[i].wa, vt[i].wd, vt[i].cs, vt[i].cr,
            vt[i].rsv, vt[i].rsd);
      #1;
      chk($sformatf("v%0d_rd_ready", i), {31'd0, bus.rd_ready}, {31'd0, vt[i].e_rrdy});
      chk($sformatf("v%0d_wr_ready", i), {31'd0, bus.wr_ready}, {31'd0, vt[i].e_wrdy});
      chk($sformatf("v%0d_rsp_valid", i), {31'd0, bus.rd_rsp_valid}, {31'd0, vt[i].rsv});
      if (vt[i].rsv) begin
        chk($sformatf("v%0d_rsp_data", i), {16'd0, bus.rd_rsp_data}, {16'd0, vt[i].rsd});
      end
      @(posedge clk);
      #2;
      chk($sformatf("v%0d_cmd_valid", i), {31'd0, bus.cmd_valid}, {31'd0, vt[i].e_cv});
      if (vt[i].e_cv) begin
        chk($sformatf("v%0d_cmd_we", i), {31'd0, bus.cmd_we}, {31'd0, vt[i].e_we});
        chk($sformatf("v%0d_cmd_addr", i), {12'd0, bus.cmd_addr}, {12'd0, vt[i].e_addr});
        if (vt[i].e_we) begin
          chk($sformatf("v%0d_cmd_wdata", i), {16'd0, bus.cmd_wdata}, {16'd0, vt[i].e_wd});
        end
      end
      @(negedge clk);
    end

    // Both requesters held: 8 reads then one forced write, repeating.
    acc = 1'b0;
    for (int i = 0; i < 27; i++) begin
      drive(1'b1, 20'(i), 1'b1, 20'h00200, 16'(i), 1'b0, 1'b1, acc, 16'(i));
      #1;
      chk($sformatf("t2_rd_ready_%0d", i), {31'd0, bus.rd_ready}, {31'd0, (i % 9) != 8});
      chk($sformatf("t2_wr_ready_%0d", i), {31'd0, bus.wr_ready}, {31'd0, (i % 9) == 8});
      acc = bus.cmd_valid && !bus.cmd_we;
      @(negedge clk);
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 20'h0, 1'b0, 20'h0, 16'h0, 1'b0, 1'b1, acc, 16'h0);
      #1;
      acc = bus.cmd_valid && !bus.cmd_we;
      @(negedge clk);
    end

    // Read credit limit, including response and grant in the same cycle.
    rd_step(1'b1, 1'b0, 1'b1, 0);
    rd_step(1'b1, 1'b0, 1'b1, 1);
    rd_step(1'b1, 1'b0, 1'b1, 2);
    rd_step(1'b1, 1'b0, 1'b1, 3);
    rd_step(1'b1, 1'b0, 1'b0, 4);
    rd_step(1'b1, 1'b1, 1'b0, 5);
    rd_step(1'b1, 1'b1, 1'b1, 6);
    rd_step(1'b1, 1'b0, 1'b1, 7);
    rd_step(1'b1, 1'b0, 1'b0, 8);
    for (int i = 9; i < 13; i++) rd_step(1'b0, 1'b1, 1'b0, i);
    rd_step(1'b1, 1'b0, 1'b1, 13);
    rd_step(1'b0, 1'b1, 1'b0, 14);

    // Framebuffer clear with a second start pulse mid-clear.
    drive(1'b0, 20'h0, 1'b0, 20'h0, 16'h0, 1'b1, 1'b1, 1'b0, 16'h0);
    #1;
    @(posedge clk);
    #2;
    chk("t4_busy_after_start", {31'd0, bus.clear_busy}, 32'd1);
    @(negedge clk);
    n_wr = 0;
    fin  = 1'b0;
    for (int k = 1; k < 60 && !fin; k++) begin
      if (!bus.clear_busy) begin
        fin = 1'b1;
      end else begin
        drive(1'b1, 20'h00033, 1'b1, 20'h00044, 16'h7777, (k == 5), 1'b1, 1'b0, 16'h0);
        #1;
        chk($sformatf("t4_rd_ready_%0d", k), {31'd0, bus.rd_ready}, 32'd0);
        chk($sformatf("t4_wr_ready_%0d", k), {31'd0, bus.wr_ready}, 32'd0);
        if (bus.cmd_valid && n_wr < 32) begin
          log_addr[n_wr] = bus.cmd_addr;
          log_wd[n_wr]   = {bus.cmd_we, bus.cmd_wdata};
          n_wr++;
        end
        @(negedge clk);
      end
    end
    drive(1'b0, 20'h0, 1'b0, 20'h0, 16'h0, 1'b0, 1'b1, 1'b0, 16'h0);
    chk("t4_clear_finished", {31'd0, fin}, 32'd1);
    chk("t4_write_count", 32'(n_wr), 32'd16);
    for (int j = 0; j < n_wr; j++) begin
      chk($sformatf("t4_addr_%0d", j), {12'd0, log_addr[j]}, 32'(j));
      chk($sformatf("t4_we_data_%0d", j), {15'd0, log_wd[j]}, 32'h0001_0000);
    end

    // Reset asserted while the clear engine is presenting address 7.
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      drive(1'b0, 20'h0, 1'b0, 20'h0, 16'h0, (k == 0), 1'b1, 1'b0, 16'h0);
      #1;
      if (k > 0 && bus.cmd_valid && bus.cmd_addr == 20'd7) begin
        found = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    chk("t5_reached_addr7", {31'd0, found}, 32'd1);
    drive(1'b1, 20'h00055, 1'b1, 20'h00066, 16'h9999, 1'b0, 1'b1, 1'b0, 16'h0);
    reset_n = 1'b0;
    #1;
    chk("t5_cmd_valid", {31'd0, bus.cmd_valid}, 32'd0);
    chk("t5_cmd_we", {31'd0, bus.cmd_we}, 32'd0);
    chk("t5_cmd_addr", {12'd0, bus.cmd_addr}, 32'd0);
    chk("t5_cmd_wdata", {16'd0, bus.cmd_wdata}, 32'd0);
    chk("t5_clear_busy", {31'd0, bus.clear_busy}, 32'd0);
    chk("t5_rd_ready", {31'd0, bus.rd_ready}, 32'd0);
    chk("t5_wr_ready", {31'd0, bus.wr_ready}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    drive(1'b0, 20'h0, 1'b0, 20'h0, 16'h0, 1'b0, 1'b1, 1'b0, 16'h0);
    reset_n = 1'b1;
    n_cmd = 0;
    for (int k = 0; k < 25; k++) begin
      #1;
      if (bus.cmd_valid || bus.clear_busy) n_cmd++;
      @(negedge clk);
    end
    chk("t5_no_activity_after_reset", 32'(n_cmd), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
